// File: rtl/operand_entry_if.sv
// ALU-facing bus of the operand entry sequencer: captured operands, mode
// and the one-cycle issue strobe. The sequencer drives the master side,
// the ALU core consumes the slave side.
interface operand_entry_if #(
  parameter int OPERAND_W = 5
);
  logic [OPERAND_W-1:0] A;
  logic [OPERAND_W-1:0] B;
  logic [1:0]           mode;
  logic                 op_valid;

  modport master (output A, B, mode, op_valid);
  modport slave  (input  A, B, mode, op_valid);
endinterface

// File: rtl/operand_entry.sv
// operand_entry: front-end input sequencer for the ALU core.
// Synchronises the slide switches and both pushbuttons, debounces the
// buttons into one-cycle press events, and walks the user through
// entering A, B and mode before issuing the triple with a one-cycle strobe.
// Optional feature macro: OPERAND_ENTRY_ECHO_EN adds echo_val/echo_active
// so the operand being dialled can be shown while in GET_A/GET_B.
module operand_entry #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int OPERAND_W       = 5
) (
  input  logic                 clock_100Mhz,
  input  logic                 reset,
  input  logic [OPERAND_W-1:0] sw_operand,
  input  logic [1:0]           sw_mode,
  input  logic                 btn_enter,
  input  logic                 btn_clear,
  output logic [2:0]           stage,
`ifdef OPERAND_ENTRY_ECHO_EN
  output logic [OPERAND_W-1:0] echo_val,
  output logic                 echo_active,
`endif
  operand_entry_if.master      alu
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Button index map for the debounce arrays.
  localparam int BTN_ENTER = 0;
  localparam int BTN_CLEAR = 1;

  typedef enum logic [2:0] {
    GET_A    = 3'd0,
    GET_B    = 3'd1,
    GET_MODE = 3'd2,
    ISSUE    = 3'd3,
    HOLD     = 3'd4
  } state_t;

  // Saturating increment for the debounce counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end
    return v + CNT_ONE;
  endfunction

  // Synchroniser stages (_p0 first flop, _sync second flop).
  logic [OPERAND_W-1:0] sw_operand_p0;
  logic [OPERAND_W-1:0] sw_operand_sync;
  logic [1:0]           sw_mode_p0;
  logic [1:0]           sw_mode_sync;
  logic [1:0]           btn_p0;
  logic [1:0]           btn_sync;

  // Debounce state per button.
  logic [1:0]           btn_prev;
  logic [1:0]           btn_stable;
  logic [1:0]           press_evt;
  logic [CNT_W-1:0]     db_cnt [2];

  logic                 enter_evt;
  logic                 clear_evt;

  // Sequencer state and datapath.
  state_t               state;
  state_t               state_next;
  logic                 cap_a;
  logic                 cap_b;
  logic                 cap_mode;
  logic [OPERAND_W-1:0] op_a;
  logic [OPERAND_W-1:0] op_b;
  logic [1:0]           op_mode;
  logic                 issue;

  // ---- stage p0/p1: two-flop synchronisers on every raw input ----
  // Bring all raw switch and button levels into the clock domain.
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      sw_operand_p0   <= '0;
      sw_operand_sync <= '0;
      sw_mode_p0      <= '0;
      sw_mode_sync    <= '0;
      btn_p0          <= '0;
      btn_sync        <= '0;
    end else begin
      sw_operand_p0   <= sw_operand;
      sw_operand_sync <= sw_operand_p0;
      sw_mode_p0      <= sw_mode;
      sw_mode_sync    <= sw_mode_p0;
      btn_p0          <= {btn_clear, btn_enter};
      btn_sync        <= btn_p0;
    end
  end

  // ---- debounce: stable level and registered press pulse ----
  // The counter restarts on any change of the synchronised level; the
  // stable level only follows once the level has held for the full window.
  // The change cycle itself is excluded so a saturated counter cannot
  // accept a fresh edge immediately.
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      btn_prev   <= '0;
      btn_stable <= '0;
      press_evt  <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      btn_prev <= btn_sync;
      for (int i = 0; i < 2; i++) begin
        press_evt[i] <= 1'b0;
        if (btn_sync[i] != btn_prev[i]) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= sat_inc(db_cnt[i]);
          if ((db_cnt[i] == CNT_MAX) && (btn_sync[i] != btn_stable[i])) begin
            btn_stable[i] <= btn_sync[i];
            press_evt[i]  <= btn_sync[i];
          end
        end
      end
    end
  end

  assign enter_evt = press_evt[BTN_ENTER];
  assign clear_evt = press_evt[BTN_CLEAR];

  // ---- sequencer FSM ----
  // State register.
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      state <= GET_A;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; clear overrides everything, including ISSUE.
  always_comb begin
    state_next = state;
    if (clear_evt) begin
      state_next = GET_A;
    end else begin
      case (state)
        GET_A:    if (enter_evt) state_next = GET_B;
        GET_B:    if (enter_evt) state_next = GET_MODE;
        GET_MODE: if (enter_evt) state_next = ISSUE;
        ISSUE:    state_next = HOLD;
        HOLD:     if (enter_evt) state_next = GET_A;
        default:  state_next = GET_A;
      endcase
    end
  end

  // Output decode: LED stage, issue strobe and capture enables.
  always_comb begin
    stage    = 3'b000;
    issue    = 1'b0;
    cap_a    = 1'b0;
    cap_b    = 1'b0;
    cap_mode = 1'b0;
    case (state)
      GET_A: begin
        stage = 3'b001;
        cap_a = enter_evt && !clear_evt;
      end
      GET_B: begin
        stage = 3'b010;
        cap_b = enter_evt && !clear_evt;
      end
      GET_MODE: begin
        stage    = 3'b100;
        cap_mode = enter_evt && !clear_evt;
      end
      ISSUE:   issue = 1'b1;
      HOLD:    stage = 3'b000;
      default: stage = 3'b000;
    endcase
  end

  // ---- capture registers presented to the ALU ----
  // Values change only at their own capture edge, so the ALU keeps showing
  // the previous result while a new sequence is being entered.
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      op_a    <= '0;
      op_b    <= '0;
      op_mode <= '0;
    end else if (clear_evt) begin
      op_a    <= '0;
      op_b    <= '0;
      op_mode <= '0;
    end else begin
      if (cap_a)    op_a    <= sw_operand_sync;
      if (cap_b)    op_b    <= sw_operand_sync;
      if (cap_mode) op_mode <= sw_mode_sync;
    end
  end

  assign alu.A        = op_a;
  assign alu.B        = op_b;
  assign alu.mode     = op_mode;
  assign alu.op_valid = issue;

`ifdef OPERAND_ENTRY_ECHO_EN
  // Registered echo of the operand being dialled; zero outside entry of A/B.
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      echo_val    <= '0;
      echo_active <= 1'b0;
    end else if ((state == GET_A) || (state == GET_B)) begin
      echo_val    <= sw_operand_sync;
      echo_active <= 1'b1;
    end else begin
      echo_val    <= '0;
      echo_active <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with a short debounce window (4 cycles).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_operand_entry;
  localparam int W  = 5;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] sw_operand;
  logic [1:0]   sw_mode;
  logic         btn_enter;
  logic         btn_clear;
  logic [2:0]   stage;
`ifdef OPERAND_ENTRY_ECHO_EN
  logic [W-1:0] echo_val;
  logic         echo_active;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  operand_entry_if #(.OPERAND_W(W)) alu ();

  operand_entry #(
    .DEBOUNCE_CYCLES(DB),
    .OPERAND_W(W)
  ) dut (
    .clock_100Mhz(clk),
    .reset(rst_n),
    .sw_operand(sw_operand),
    .sw_mode(sw_mode),
    .btn_enter(btn_enter),
    .btn_clear(btn_clear),
    .stage(stage),
`ifdef OPERAND_ENTRY_ECHO_EN
    .echo_val(echo_val),
    .echo_active(echo_active),
`endif
    .alu(alu)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [1:0] m, input logic ov, input logic [2:0] st);
    check({tag, ".A"},     32'(alu.A),        32'(a));
    check({tag, ".B"},     32'(alu.B),        32'(b));
    check({tag, ".mode"},  32'(alu.mode),     32'(m));
    check({tag, ".valid"}, 32'(alu.op_valid), 32'(ov));
    check({tag, ".stage"}, 32'(stage),        32'(st));
  endtask

  // Raise the chosen buttons and wait until the capture edge has passed
  // (event at N+2+DB, capture at N+3+DB, seen on the following fall).
  task automatic press(input logic ent, input logic clr);
    btn_enter = ent;
    btn_clear = clr;
    tick(DB + 4);
  endtask

  task automatic release_btns();
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    tick(12);
  endtask

  initial begin
    rst_n      = 1'b0;
    btn_enter  = 1'b1;
    btn_clear  = 1'b0;
    sw_operand = 5'h1F;
    sw_mode    = 2'b11;

    // Reset held with enter pressed and switches high.
    tick(1);
    check_outs("rst0", 5'd0, 5'd0, 2'd0, 1'b0, 3'b001);
    tick(5);
    check_outs("rst1", 5'd0, 5'd0, 2'd0, 1'b0, 3'b001);

    // Release reset: enter still held, so it is accepted after the full latency.
    rst_n = 1'b1;
    tick(DB + 3);
    check("lat_pre.stage", 32'(stage), 32'(3'b001));
    check("lat_pre.A",     32'(alu.A), 32'(5'd0));
    tick(1);
    check("lat_post.stage", 32'(stage), 32'(3'b010));
    check("lat_post.A",     32'(alu.A), 32'(5'h1F));
    release_btns();

    // Clear while in GET_B.
    press(1'b0, 1'b1);
    check_outs("clr_getb", 5'd0, 5'd0, 2'd0, 1'b0, 3'b001);
    release_btns();

    // Full entry 13 / 7 / mode 2.
    sw_operand = 5'd13;
    press(1'b1, 1'b0);
    check_outs("ent_a", 5'd13, 5'd0, 2'd0, 1'b0, 3'b010);
    release_btns();
    sw_operand = 5'd7;
    press(1'b1, 1'b0);
    check_outs("ent_b", 5'd13, 5'd7, 2'd0, 1'b0, 3'b100);
    release_btns();
    sw_mode = 2'b10;
    press(1'b1, 1'b0);
    check_outs("issue", 5'd13, 5'd7, 2'd2, 1'b1, 3'b000);
    tick(1);
    check_outs("hold0", 5'd13, 5'd7, 2'd2, 1'b0, 3'b000);
    release_btns();
    check_outs("hold1", 5'd13, 5'd7, 2'd2, 1'b0, 3'b000);

    // Re-entry from HOLD: first press only returns to GET_A.
    sw_operand = 5'd2;
    press(1'b1, 1'b0);
    check_outs("reent0", 5'd13, 5'd7, 2'd2, 1'b0, 3'b001);
    release_btns();
    press(1'b1, 1'b0);
    check_outs("reent1", 5'd2, 5'd7, 2'd2, 1'b0, 3'b010);
    release_btns();

    // Bouncing enter: 2-cycle pulses for 20 cycles, then a solid hold.
    sw_operand = 5'd9;
    for (int i = 0; i < 20; i++) begin
      btn_enter = ((i % 4) < 2) ? 1'b1 : 1'b0;
      tick(1);
    end
    btn_enter = 1'b1;
    tick(DB + 3);
    check("bnc_pre.stage", 32'(stage), 32'(3'b010));
    check("bnc_pre.B",     32'(alu.B), 32'(5'd7));
    tick(1);
    check("bnc_post.stage", 32'(stage), 32'(3'b100));
    check("bnc_post.B",     32'(alu.B), 32'(5'd9));
    release_btns();
    check("bnc_once.stage", 32'(stage), 32'(3'b100));

    // A 3-cycle glitch alone is rejected.
    sw_mode   = 2'b01;
    btn_enter = 1'b1;
    tick(3);
    btn_enter = 1'b0;
    tick(15);
    check("glitch.stage", 32'(stage),    32'(3'b100));
    check("glitch.mode",  32'(alu.mode), 32'(2'd2));

    // Enter and clear together in GET_MODE: clear wins, no issue.
    press(1'b1, 1'b1);
    check_outs("both", 5'd0, 5'd0, 2'd0, 1'b0, 3'b001);
    release_btns();

    // New sequence 21 / 3 / mode 1, then clear from HOLD.
    sw_operand = 5'd21;
    press(1'b1, 1'b0);
    release_btns();
    sw_operand = 5'd3;
    press(1'b1, 1'b0);
    release_btns();
    press(1'b1, 1'b0);
    check_outs("issue2", 5'd21, 5'd3, 2'd1, 1'b1, 3'b000);
    release_btns();
    btn_clear = 1'b1;
    tick(DB + 3);
    check_outs("hclr_pre", 5'd21, 5'd3, 2'd1, 1'b0, 3'b000);
    tick(1);
    check_outs("hclr_post", 5'd0, 5'd0, 2'd0, 1'b0, 3'b001);
    release_btns();

    // Asynchronous reset in GET_B, between clock edges.
    sw_operand = 5'd6;
    press(1'b1, 1'b0);
    check_outs("pre_arst", 5'd6, 5'd0, 2'd0, 1'b0, 3'b010);
    btn_enter = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("arst", 5'd0, 5'd0, 2'd0, 1'b0, 3'b001);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check_outs("arst_rel", 5'd0, 5'd0, 2'd0, 1'b0, 3'b001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
